// File: rtl/arrow_game_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the arrow game scheduler.
// Combinational helpers only; no state lives here.
package arrow_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_ACTIVE   = 2'd1,
        SLOT_COOLDOWN = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [1:0] direction;
        logic       inversed;
        logic [2:0] speed;
    } slot_cfg_t;

    localparam logic [1:0] DIR_TOP    = 2'b00;
    localparam logic [1:0] DIR_BOTTOM = 2'b01;
    localparam logic [1:0] DIR_LEFT   = 2'b10;
    localparam logic [1:0] DIR_RIGHT  = 2'b11;

    // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Arrows speed up by one step per eight blocked arrows, capped at 7.
    function automatic logic [2:0] spawn_speed(input logic [7:0] score);
        return (score[7:3] >= 5'd6) ? 3'd7 : score[5:3] + 3'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
`timescale 1ns/1ps
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
// Exposes only the low bits consumed by the spawn logic; no backpressure.
module lfsr16
    import arrow_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] rnd
);

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign rnd = state_q[2:0];

endmodule

// File: rtl/arrow_scheduler.sv
`timescale 1ns/1ps
// Game controller: spawns arrows into free slots each spawn period, tallies blocks and player hits.
// All outputs registered, one cycle after the causing input; slots have no backpressure, full spawns drop.
module arrow_scheduler
    import arrow_game_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned SPAWN_PERIOD = 60,
    parameter int unsigned LIVES        = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      start_in,
    input  logic [NUM_SLOTS-1:0]      slot_hit_in,
    input  logic [NUM_SLOTS-1:0]      slot_hit_player_in,
    output logic [NUM_SLOTS-1:0]      slot_valid_out,
    output logic [NUM_SLOTS-1:0][1:0] slot_direction_out,
    output logic [NUM_SLOTS-1:0]      slot_inversed_out,
    output logic [NUM_SLOTS-1:0][2:0] slot_speed_out,
    output logic [1:0]                lives_out,
    output logic [7:0]                score_out,
    output logic [1:0]                state_out,
    output logic                      game_over_out
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam int EVT_W = $clog2(NUM_SLOTS + 1);

    // Assertion is immediate; release is retimed so no flop sees a partial deassert.
    logic rst_meta;
    logic rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    logic [2:0] rnd;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst_sync),
        .rnd (rnd)
    );

    game_state_t          state_q;
    logic [1:0]           lives_q;
    logic [7:0]           score_q;
    logic [CNT_W-1:0]     spawn_cnt_q;

    logic                 tick;
    logic                 run;
    logic                 spawn;
    logic                 taken;
    logic [NUM_SLOTS-1:0] is_free;
    logic [NUM_SLOTS-1:0] is_active;
    logic [NUM_SLOTS-1:0] grant;
    logic [NUM_SLOTS-1:0] player_evt;
    logic [NUM_SLOTS-1:0] block_evt;
    logic [EVT_W-1:0]     n_player;
    logic [EVT_W-1:0]     n_block;
    logic [8:0]           score_sum;
    logic [7:0]           score_next;
    logic [1:0]           lives_next;
    slot_cfg_t            new_cfg;

    always_comb begin
        tick  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        // The PLAY cycle after lives hit zero is spent tearing down, not playing.
        run   = (state_q == PLAY) && (lives_q != 2'd0);
        spawn = run && tick && (spawn_cnt_q == CNT_LAST);

        grant      = '0;
        player_evt = '0;
        block_evt  = '0;
        n_player   = '0;
        n_block    = '0;
        taken      = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (run && is_active[i] && slot_hit_in[i]) begin
                player_evt[i] = slot_hit_player_in[i];
                block_evt[i]  = ~slot_hit_player_in[i];
            end
            n_player = n_player + EVT_W'(player_evt[i]);
            n_block  = n_block + EVT_W'(block_evt[i]);
            if (!taken && is_free[i]) begin
                grant[i] = spawn;
                taken    = 1'b1;
            end
        end

        score_sum  = {1'b0, score_q} + 9'(n_block);
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (8'(n_player) >= 8'(lives_q)) begin
            lives_next = 2'd0;
        end else begin
            lives_next = lives_q - 2'(n_player);
        end

        new_cfg.direction = rnd[1:0];
        new_cfg.inversed  = rnd[2] & ((rnd[1:0] == DIR_TOP) || (rnd[1:0] == DIR_BOTTOM));
        new_cfg.speed     = spawn_speed(score_q);
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state_q       <= IDLE;
            lives_q       <= 2'd0;
            score_q       <= 8'd0;
            spawn_cnt_q   <= '0;
            game_over_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    if (start_in) begin
                        state_q       <= PLAY;
                        lives_q       <= 2'(LIVES);
                        score_q       <= 8'd0;
                        spawn_cnt_q   <= '0;
                        game_over_out <= 1'b0;
                    end
                end
                PLAY: begin
                    if (lives_q == 2'd0) begin
                        state_q       <= OVER;
                        game_over_out <= 1'b1;
                    end else begin
                        lives_q <= lives_next;
                        score_q <= score_next;
                        if (tick) begin
                            spawn_cnt_q <= spawn ? '0 : spawn_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lives_out = lives_q;
    assign score_out = score_q;
    assign state_out = state_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_state_t slot_q;
        slot_cfg_t   cfg_q;

        // Config only loads on spawn, so it stays stable through ACTIVE and COOLDOWN.
        always_ff @(posedge clk or negedge rst_sync) begin
            if (!rst_sync) begin
                slot_q <= SLOT_FREE;
                cfg_q  <= '0;
            end else if (!run) begin
                slot_q <= SLOT_FREE;
            end else begin
                case (slot_q)
                    SLOT_FREE: begin
                        if (grant[g]) begin
                            slot_q <= SLOT_ACTIVE;
                            cfg_q  <= new_cfg;
                        end
                    end
                    SLOT_ACTIVE: begin
                        if (slot_hit_in[g]) slot_q <= SLOT_COOLDOWN;
                    end
                    SLOT_COOLDOWN: begin
                        if (tick) slot_q <= SLOT_FREE;
                    end
                    default: slot_q <= SLOT_FREE;
                endcase
            end
        end

        assign is_free[g]            = (slot_q == SLOT_FREE);
        assign is_active[g]          = (slot_q == SLOT_ACTIVE);
        assign slot_valid_out[g]     = is_active[g];
        assign slot_direction_out[g] = cfg_q.direction;
        assign slot_inversed_out[g]  = cfg_q.inversed;
        assign slot_speed_out[g]     = cfg_q.speed;
    end

endmodule

// File: tb/tb_arrow_scheduler.sv
`timescale 1ns/1ps
// Directed bench for arrow_scheduler with a cycle-level reference model of the game rules.
module tb_arrow_scheduler;

    localparam int NS          = 4;
    localparam int PERIOD      = 60;
    localparam int LIV         = 3;
    localparam int SYNC_STAGES = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [10:0]        hcount = 11'd5;
    logic [9:0]         vcount = 10'd5;
    logic               start = 1'b0;
    logic [NS-1:0]      hit = '0;
    logic [NS-1:0]      hitp = '0;
    logic [NS-1:0]      valid_o;
    logic [NS-1:0][1:0] dir_o;
    logic [NS-1:0]      inv_o;
    logic [NS-1:0][2:0] spd_o;
    logic [1:0]         lives_o;
    logic [7:0]         score_o;
    logic [1:0]         state_o;
    logic               go_o;

    arrow_scheduler #(
        .NUM_SLOTS    (NS),
        .SPAWN_PERIOD (PERIOD),
        .LIVES        (LIV),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .hcount_in          (hcount),
        .vcount_in          (vcount),
        .start_in           (start),
        .slot_hit_in        (hit),
        .slot_hit_player_in (hitp),
        .slot_valid_out     (valid_o),
        .slot_direction_out (dir_o),
        .slot_inversed_out  (inv_o),
        .slot_speed_out     (spd_o),
        .lives_out          (lives_o),
        .score_out          (score_o),
        .state_out          (state_o),
        .game_over_out      (go_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: states 0=idle 1=play 2=over; slots 0=free 1=active 2=cooldown.
    int          m_state, m_lives, m_score, m_cnt, m_sync;
    int          m_slot[NS];
    int          m_dir[NS];
    int          m_inv[NS];
    int          m_spd[NS];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_cnt = 0; m_sync = 0;
        m_lfsr  = 16'hACE1;
        for (int i = 0; i < NS; i++) begin
            m_slot[i] = 0; m_dir[i] = 0; m_inv[i] = 0; m_spd[i] = 0;
        end
    endtask

    task automatic model_step();
        bit tk, spn;
        int players, blocks, fidx;
        int ns[NS];
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_sync < SYNC_STAGES) begin
            m_sync++;
            return;
        end
        tk = (hcount == 0) && (vcount == 0);
        if (m_state == 1) begin
            if (m_lives == 0) begin
                m_state = 2;
                for (int i = 0; i < NS; i++) m_slot[i] = 0;
            end else begin
                players = 0; blocks = 0; fidx = -1;
                for (int i = 0; i < NS; i++) begin
                    ns[i] = m_slot[i];
                    if (fidx < 0 && m_slot[i] == 0) fidx = i;
                    if (m_slot[i] == 1 && hit[i]) begin
                        ns[i] = 2;
                        if (hitp[i]) players++; else blocks++;
                    end else if (m_slot[i] == 2 && tk) begin
                        ns[i] = 0;
                    end
                end
                spn = tk && (m_cnt == PERIOD - 1);
                if (spn && fidx >= 0) begin
                    ns[fidx]    = 1;
                    m_dir[fidx] = int'(m_lfsr[1:0]);
                    m_inv[fidx] = (m_lfsr[2] && !m_lfsr[1]) ? 1 : 0;
                    m_spd[fidx] = (1 + m_score / 8 > 7) ? 7 : 1 + m_score / 8;
                end
                if (tk) m_cnt = spn ? 0 : m_cnt + 1;
                m_lives = (players >= m_lives) ? 0 : m_lives - players;
                m_score = (m_score + blocks > 255) ? 255 : m_score + blocks;
                for (int i = 0; i < NS; i++) m_slot[i] = ns[i];
            end
        end else if (start) begin
            m_state = 1; m_lives = LIV; m_score = 0; m_cnt = 0;
            for (int i = 0; i < NS; i++) m_slot[i] = 0;
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic compare_all();
        int vv, dv, iv, sv;
        vv = 0; dv = 0; iv = 0; sv = 0;
        for (int i = 0; i < NS; i++) begin
            vv |= (m_slot[i] == 1 ? 1 : 0) << i;
            dv |= m_dir[i] << (2 * i);
            iv |= m_inv[i] << i;
            sv |= m_spd[i] << (3 * i);
        end
        check("m_state", int'(state_o), m_state);
        check("m_lives", int'(lives_o), m_lives);
        check("m_score", int'(score_o), m_score);
        check("m_game_over", int'(go_o), (m_state == 2) ? 1 : 0);
        check("m_valid", int'(valid_o), vv);
        check("m_direction", int'(dir_o), dv);
        check("m_inversed", int'(inv_o), iv);
        check("m_speed", int'(spd_o), sv);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            hcount = 11'd0; vcount = 10'd0;
            @(negedge clk);
            hcount = 11'd5; vcount = 10'd5;
            @(negedge clk);
        end
    endtask

    task automatic hit_once(input logic [NS-1:0] h, input logic [NS-1:0] p);
        hit = h; hitp = p;
        @(negedge clk);
        hit = '0; hitp = '0;
    endtask

    task automatic start_once();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", int'(state_o), 0);
        check("reset_lives", int'(lives_o), 0);
        check("reset_score", int'(score_o), 0);
        check("reset_game_over", int'(go_o), 0);
        check("reset_valid", int'(valid_o), 0);

        start_once();
        check("start_state", int'(state_o), 1);
        check("start_lives", int'(lives_o), 3);
        check("start_score", int'(score_o), 0);

        tick_n(PERIOD - 1);
        check("pre_spawn_valid", int'(valid_o), 0);
        tick_n(1);
        check("first_spawn_valid", int'(valid_o), 4'b0001);
        check("first_spawn_speed", int'(spd_o[0]), 1);

        hit_once(4'b0001, 4'b0000);
        check("block_score", int'(score_o), 1);
        check("block_valid", int'(valid_o), 0);
        tick_n(1);

        tick_n(PERIOD - 1 + 3 * PERIOD);
        check("fill_valid", int'(valid_o), 4'b1111);
        tick_n(PERIOD);
        check("drop_spawn_valid", int'(valid_o), 4'b1111);

        hit_once(4'b1111, 4'b0000);
        check("multi_block_score", int'(score_o), 5);
        check("multi_block_valid", int'(valid_o), 0);
        tick_n(1);
        tick_n(PERIOD - 1);
        check("wrap_spawn_valid", int'(valid_o), 4'b0001);
        tick_n(3 * PERIOD);
        check("refill_valid", int'(valid_o), 4'b1111);

        hit_once(4'b1001, 4'b0001);
        check("mixed_lives", int'(lives_o), 2);
        check("mixed_score", int'(score_o), 6);
        hit_once(4'b0110, 4'b0110);
        check("double_hit_lives", int'(lives_o), 0);
        check("double_hit_state", int'(state_o), 1);
        @(negedge clk);
        check("over_state", int'(state_o), 2);
        check("over_game_over", int'(go_o), 1);
        check("over_valid", int'(valid_o), 0);

        start_once();
        check("restart_state", int'(state_o), 1);
        check("restart_lives", int'(lives_o), 3);
        check("restart_score", int'(score_o), 0);
        check("restart_game_over", int'(go_o), 0);

        tick_n(4 * PERIOD);
        check("third_fill_valid", int'(valid_o), 4'b1111);
        hit_once(4'b1000, 4'b0000);
        check("cooldown_valid", int'(valid_o), 4'b0111);

        #2 rst = 1'b0;
        #1;
        check("async_rst_state", int'(state_o), 0);
        check("async_rst_valid", int'(valid_o), 0);
        check("async_rst_direction", int'(dir_o), 0);
        check("async_rst_inversed", int'(inv_o), 0);
        check("async_rst_speed", int'(spd_o), 0);
        check("async_rst_lives", int'(lives_o), 0);
        check("async_rst_score", int'(score_o), 0);
        check("async_rst_game_over", int'(go_o), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        start_once();
        tick_n(PERIOD);
        check("post_rst_spawn_valid", int'(valid_o), 4'b0001);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arrow_scheduler.md
ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of arrow instances driven.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 60: frames between spawn attempts.
REQ-003 SHALL have parameter LIVES, default 3: lives loaded on game start.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value, nonzero.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports hcount_in (11) and vcount_in (10), inputs: raster position.
REQ-008 SHALL have port start_in, input, 1: start or restart request.
REQ-009 SHALL have port slot_hit_in, input, NUM_SLOTS: per-slot arrow is_hit level.
REQ-010 SHALL have port slot_hit_player_in, input, NUM_SLOTS: per-slot arrow hit_player pulse.
REQ-011 SHALL have port slot_valid_out, output, NUM_SLOTS: per-slot arrow valid_in.
REQ-012 SHALL have ports slot_direction_out (NUM_SLOTS x 2), slot_inversed_out (NUM_SLOTS) and slot_speed_out (NUM_SLOTS x 3), outputs: per-slot arrow configuration.
REQ-013 SHALL have outputs lives_out (2), score_out (8), state_out (2) and game_over_out (1).

Function
REQ-014 SHALL define the frame tick as hcount_in==0 && vcount_in==0, sampled combinationally.
REQ-015 SHALL implement game states IDLE=0, PLAY=1 and OVER=2, presented on state_out.
REQ-016 In IDLE and OVER, a start_in sampled high SHALL enter PLAY the next cycle, with lives=LIVES, score=0, spawn counter=0 and all slots FREE.
REQ-017 start_in SHALL be ignored while in PLAY.
REQ-018 In PLAY, the spawn counter SHALL increment on each tick; on the tick where it equals SPAWN_PERIOD-1, it SHALL wrap to 0 and a spawn attempt SHALL occur.
REQ-019 A spawn attempt SHALL take the lowest-index FREE slot; if no slot is FREE, the spawn SHALL be dropped silently.
REQ-020 Each slot SHALL have states FREE, ACTIVE and COOLDOWN; slot_valid_out SHALL be 1 only in ACTIVE.
REQ-021 On spawn, the slot SHALL go to ACTIVE with direction=lfsr[1:0] and inversed=lfsr[2] & ~lfsr[1], so that only vertical arrows are inverted.
REQ-022 On spawn, speed SHALL be min(7, 1+(score>>3)).
REQ-023 Slot configuration outputs SHALL be held constant while the slot is ACTIVE or in COOLDOWN.
REQ-024 An ACTIVE slot with slot_hit_in=1 SHALL move to COOLDOWN the next cycle, which drops its valid.
REQ-025 Classification of that hit SHALL occur on the same cycle: if slot_hit_player_in=1, it is a player hit; otherwise it is a block.
REQ-026 COOLDOWN SHALL return to FREE on the next tick, guaranteeing valid stays low for at least one full frame so the arrow sees a fresh rising edge.
REQ-027 Simultaneous events across slots SHALL be summed in the same cycle.
REQ-028 lives SHALL decrease by the number of player hits, saturating at 0.
REQ-029 score SHALL increase by the number of blocks, saturating at 255.
REQ-030 lives reaching 0 SHALL enter OVER the next cycle; in OVER, all slots SHALL be forced FREE and game_over_out=1.
REQ-031 The LFSR SHALL be 16-bit Galois with taps 16,14,13,11, advancing every cycle in all states.

Reset
REQ-032 Asserting rst low SHALL immediately, even mid-frame or mid-spawn, force state IDLE, all slots FREE, and all slot outputs 0.
REQ-033 Reset SHALL also set lives_out=0, score_out=0, game_over_out=0, spawn counter=0 and lfsr=LFSR_SEED.
REQ-034 Release of reset SHALL be synchronized so that the first active edge sees all flops reset.

Structure
REQ-035 Package arrow_game_pkg SHALL hold game_state_t and slot_state_t.
REQ-036 arrow_game_pkg SHALL hold the direction constants DIR_TOP=00, DIR_BOTTOM=01, DIR_LEFT=10 and DIR_RIGHT=11, plus the LFSR tap mask.
REQ-037 The LFSR SHALL be a separate sub-module, lfsr16; the slot array SHALL be a generate loop within arrow_scheduler.

Verification
REQ-038 Reset, then start_in pulse, then 60 ticks -> slot 0 valid=1 and slots 1-3 valid=0, with direction equal to lfsr[1:0] at spawn.
REQ-039 Slot 0 ACTIVE, slot_hit_in[0]=1 with slot_hit_player_in[0]=0 -> score 0->1, slot 0 valid low next cycle, FREE after next tick.
REQ-040 All 4 slots ACTIVE, spawn tick -> no change to any slot, counter wraps to 0.
REQ-041 Player hits on slots 1 and 2 in the same cycle with lives=2 -> lives=0, then OVER, all valid=0, game_over_out=1; start_in -> PLAY with lives=3 and score=0.
REQ-042 rst asserted while slot 3 is in COOLDOWN mid-frame -> all outputs 0 immediately, state IDLE, lfsr=16'hACE1.
